// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
// PC/index widths, FSM state encoding and the PC type.
package pc_pkg;

  localparam int PC_W  = 12;
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESOLVE,
    HALTED
  } pc_state_t;

  typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/pc_perf_cnt.sv
// Saturating 16-bit event counter.
// Ports: clk, reset (sync, high), inc (count enable), cnt (value).
module pc_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential step, taken branches via external
// offset LUT (1 bubble, flagged by flush), stall, halt and restart.
// Ports: clk, reset (sync, high), start, stall, halt, br_req,
//   br_cond, br_idx -> lut_addr; lut_target (signed offset) in;
//   pc, flush, done out.
// Optional: PC_PERF_CNT_EN adds br_taken_cnt and stall_cnt outputs.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int IW       = IDX_W,
  parameter int START_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          br_req,
  input  logic          br_cond,
  input  logic [IW-1:0] br_idx,
  output logic [IW-1:0] lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
`ifdef PC_PERF_CNT_EN
  output logic [15:0]   br_taken_cnt,
  output logic [15:0]   stall_cnt,
`endif
  output logic          flush,
  output logic          done
);

  localparam logic [D-1:0] START = D'(START_PC);

  pc_state_t     state, state_n;
  logic [D-1:0]  pc_n;
  logic [IW-1:0] addr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= START;
      lut_addr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      lut_addr <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = lut_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START;
        end
      end
      RUN: begin
        priority case (1'b1)
          halt:  state_n = HALTED;
          stall: ;
          (br_req && br_cond): begin
            addr_n  = br_idx;
            state_n = RESOLVE;
          end
          default: pc_n = pc + 1'b1;
        endcase
      end
      RESOLVE: begin
        // carry is dropped: negative offsets are modular adds
        if (!stall) begin
          pc_n    = pc + lut_target;
          state_n = RUN;
        end
      end
      HALTED: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign flush = (state == RESOLVE);
  assign done  = (state == HALTED);

`ifdef PC_PERF_CNT_EN
  logic bt_inc;
  logic st_inc;

  assign bt_inc = (state == RUN) && !halt && !stall
                  && br_req && br_cond;
  assign st_inc = stall
                  && (state == RUN || state == RESOLVE);

  pc_perf_cnt u_bt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bt_inc),
    .cnt   (br_taken_cnt)
  );

  pc_perf_cnt u_st_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (st_inc),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then
// randomized traffic, checked against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt, br_req, br_cond;
  logic [7:0]  br_idx;
  logic [7:0]  lut_addr;
  logic [11:0] lut_target;
  logic [11:0] pc;
  logic        flush, done;
`ifdef PC_PERF_CNT_EN
  logic [15:0] br_taken_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  logic [11:0] lut [256];
  assign lut_target = lut[lut_addr];

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt         (halt),
    .br_req       (br_req),
    .br_cond      (br_cond),
    .br_idx       (br_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .pc           (pc),
`ifdef PC_PERF_CNT_EN
    .br_taken_cnt (br_taken_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .flush        (flush),
    .done         (done)
  );

  typedef struct {
    logic [11:0] pc;
    logic [7:0]  addr;
    logic        flush;
    logic        done;
    int          bt;
    int          sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model: sequencer is off, fetching, waiting on an offset, or stopped
  localparam int M_OFF = 0, M_GO = 1, M_WAIT = 2, M_STOP = 3;
  int          m_mode = M_OFF;
  logic [11:0] m_pc = 12'd0;
  logic [7:0]  m_addr = 8'd0;
  int          m_bt = 0, m_sc = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic step(input logic r, s, sl, h, bq, bc,
                      input logic [7:0] ix);
    exp_t e;
    @(negedge clk);
    #1;
    reset = r; start = s; stall = sl; halt = h;
    br_req = bq; br_cond = bc; br_idx = ix;
    if (r) begin
      m_mode = M_OFF; m_pc = 12'd0; m_addr = 8'd0;
      m_bt = 0; m_sc = 0;
    end else if (m_mode == M_OFF || m_mode == M_STOP) begin
      if (s) begin m_mode = M_GO; m_pc = 12'd0; end
    end else if (m_mode == M_GO) begin
      if (sl) m_sc = sat(m_sc);
      if (h) m_mode = M_STOP;
      else if (sl) ;
      else if (bq && bc) begin
        m_addr = ix; m_mode = M_WAIT; m_bt = sat(m_bt);
      end else m_pc = m_pc + 12'd1;
    end else begin
      if (sl) m_sc = sat(m_sc);
      else begin
        m_pc = 12'((int'(m_pc) + int'(lut[m_addr])) % 4096);
        m_mode = M_GO;
      end
    end
    e.pc = m_pc; e.addr = m_addr;
    e.flush = (m_mode == M_WAIT);
    e.done = (m_mode == M_STOP);
    e.bt = m_bt; e.sc = m_sc;
    sb.push_back(e);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 8'($urandom));
  endtask

  task automatic br(input logic c, input logic [7:0] ix);
    step(0, 0, 0, 0, 1, c, ix);
  endtask

  task automatic goto(input int n);
    step(1, 0, 0, 0, 0, 0, 8'd0);
    step(0, 1, 0, 0, 0, 0, 8'd0);
    repeat (n) nop();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", int'(pc), int'(e.pc));
        chk("lut_addr", int'(lut_addr), int'(e.addr));
        chk("flush", int'(flush), int'(e.flush));
        chk("done", int'(done), int'(e.done));
`ifdef PC_PERF_CNT_EN
        chk("br_taken_cnt", int'(br_taken_cnt), e.bt);
        chk("stall_cnt", int'(stall_cnt), e.sc);
`endif
      end
    end
  end

  initial begin : stim
    reset = 1; start = 0; stall = 0; halt = 0;
    br_req = 0; br_cond = 0; br_idx = 0;
    for (int i = 0; i < 256; i++) lut[i] = 12'($urandom);
    lut[0] = 12'd133;
    lut[1] = 12'hFE8;
    lut[2] = 12'd0;
    lut[3] = 12'd7;

    goto(5);
    goto(20); br(1, 8'd0); nop(); nop();
    goto(30); br(1, 8'd1); nop();
    goto(10); br(1, 8'd1); nop(); nop();
    goto(40); br(0, 8'd3); br(1, 8'd3);
    repeat (3) step(0, 0, 1, 0, 1, 1, 8'($urandom));
    nop(); nop();
    goto(50); step(0, 0, 0, 1, 1, 1, 8'd0); nop();
    step(0, 1, 0, 0, 0, 0, 8'd0); nop();
    goto(5); br(1, 8'd0);
    step(1, 0, 0, 0, 0, 0, 8'd0); nop();
    goto(3); br(1, 8'd2); nop(); nop();
    goto(1); br(1, 8'd0); nop();
    step(0, 0, 1, 0, 0, 0, 8'd0);
    br(1, 8'd3); step(0, 0, 1, 0, 0, 0, 8'd0);
    step(0, 0, 1, 0, 0, 0, 8'd0); nop();

    step(1, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) == 0,
           1'($urandom),
           8'($urandom_range(0, 5)));
    end
    nop();

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
